// File: rtl/sram_sp_req_ctrl.sv
// Purpose: valid/ready request front end for a 4k x 32 single-port SRAM (reads, byte-masked writes).
// Latency: a read accepted in cycle N gives rsp_valid at N+2 at the earliest. Writes produce no response.
// Backpressure: req_ready is held low while the response FIFO credits (entries + in-flight read) are used up.
//   It is also low during zeroize and during reset. rsp_rdata holds while rsp_valid & !rsp_ready.
// Ports:
//   CLK, reset       : clock; synchronous active-high reset
//   req_*            : request stream (valid/ready, write, be, addr, wdata)
//   rsp_*            : read response stream (valid/ready, rdata), returned in request order
//   busy             : zeroize running, read in flight, or responses pending
//   mem_me/we/adr/d  : SRAM strobes; mem_q is SRAM read data, valid the cycle after a read access
// Option: define SRAM_SP_REQ_CTRL_ZEROIZE_EN to clear the whole array after every reset.
module sram_sp_req_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [3:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_me,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_inflight;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

  logic              zeroize_active;
  logic [ADDR_W-1:0] zero_addr;
  logic              rst_busy;

  logic [CNT_W:0]    credits_used;
  logic              credit_ok;
  logic              accept;
  logic              rd_accept;
  logic              req_nop;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef SRAM_SP_REQ_CTRL_ZEROIZE_EN
  typedef enum logic {ZS_RUN, ZS_CLEAR} zs_t;
  zs_t zs_q;
  zs_t zs_d;

  assign rst_busy = 1'b1;

  // Walk restarts from address 0 on every reset, including one in mid-walk.
  always_ff @(posedge CLK) begin
    if (reset) begin
      zs_q      <= ZS_CLEAR;
      zero_addr <= '0;
    end else begin
      zs_q <= zs_d;
      if (zs_q == ZS_CLEAR) zero_addr <= zero_addr + 1'b1;
    end
  end

  always_comb begin
    zs_d = zs_q;
    if (zs_q == ZS_CLEAR && zero_addr == '1) zs_d = ZS_RUN;
  end

  always_comb begin
    zeroize_active = (zs_q == ZS_CLEAR);
  end
`else
  assign rst_busy       = 1'b0;
  assign zeroize_active = 1'b0;
  assign zero_addr      = '0;
`endif

  // Credits count the read already in flight, so the FIFO can never overflow.
  // A pop in the same cycle is not credited back, which keeps the ready path short.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight};
  assign credit_ok    = credits_used < (CNT_W + 1)'(RSP_DEPTH);
  assign req_ready    = !reset && !zeroize_active && credit_ok;

  assign accept    = req_valid && req_ready;
  assign req_nop   = req_write && (req_be == 4'h0);
  assign rd_accept = accept && !req_write;

  always_comb begin
    mem_me  = 1'b0;
    mem_we  = 4'h0;
    mem_adr = '0;
    mem_d   = '0;
    if (!reset) begin
      if (zeroize_active) begin
        mem_me  = 1'b1;
        mem_we  = 4'hF;
        mem_adr = zero_addr;
      end else begin
        mem_adr = req_addr;
        mem_d   = req_wdata;
        mem_me  = accept && !req_nop;
        mem_we  = (accept && req_write) ? req_be : 4'h0;
      end
    end
  end

  // mem_q is valid exactly one cycle after a read access, i.e. while rd_inflight is set.
  assign push = rd_inflight;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_inflight <= 1'b0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      rd_inflight <= rd_accept;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; the count qualifies every entry.
  always_ff @(posedge CLK) begin
    if (push && !reset) fifo_mem[wr_ptr] <= mem_q;
  end

  assign rsp_valid = !reset && (fifo_count != '0);
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

  assign busy = reset ? rst_busy
                      : (zeroize_active || rd_inflight || (fifo_count != '0));

endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// Directed bench for sram_sp_req_ctrl with a behavioural 4k x 32 SRAM model.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled before the next rising edge.
module tb_sram_sp_req_ctrl;

`ifdef SRAM_SP_REQ_CTRL_ZEROIZE_EN
  localparam logic [31:0] RST_BUSY_EXP = 32'd1;
  localparam logic [31:0] RD5_AFTER_RST = 32'h0000_0000;
`else
  localparam logic [31:0] RST_BUSY_EXP = 32'd0;
  localparam logic [31:0] RD5_AFTER_RST = 32'hDEAD_BEEF;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_be;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        mem_me;
  logic [3:0]  mem_we;
  logic [11:0] mem_adr;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  int checks   = 0;
  int failures = 0;
  int n_wait;

  always #5 CLK = ~CLK;

  sram_sp_req_ctrl #(.ADDR_W(12), .DATA_W(32), .RSP_DEPTH(2)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_me    (mem_me),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  // SRAM model: byte-masked write, or a read with Q registered for the next cycle.
  logic [31:0] sram [4096];
  always @(posedge CLK) begin
    if (mem_me) begin
      if (mem_we == 4'h0) begin
        mem_q <= sram[mem_adr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[mem_adr][8*b +: 8] <= mem_d[8*b +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = 4'h0;
    req_addr  = 12'h000;
    req_wdata = 32'h0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                          input string tag);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_be    = be;
    req_addr  = a;
    req_wdata = d;
    #1;
    check_val({tag, "_rdy"}, 32'(req_ready), 32'd1);
    check_val({tag, "_me"},  32'(mem_me), (be != 4'h0) ? 32'd1 : 32'd0);
    check_val({tag, "_we"},  32'(mem_we), 32'(be));
    tick;
    idle;
  endtask

  task automatic read_expect(input logic [11:0] a, input logic [31:0] exp, input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_be    = 4'hF;
    req_addr  = a;
    #1;
    check_val({tag, "_me"}, 32'(mem_me), 32'd1);
    check_val({tag, "_we"}, 32'(mem_we), 32'd0);
    tick;
    idle;
    check_val({tag, "_vld_n1"}, 32'(rsp_valid), 32'd0);
    tick;
    check_val({tag, "_vld_n2"}, 32'(rsp_valid), 32'd1);
    check_val({tag, "_data"}, rsp_rdata, exp);
    tick;
  endtask

  task automatic wait_ready(input int limit, input string tag, output int n);
    n = 0;
    while (!req_ready && n < limit) begin
      tick;
      n++;
    end
    check_val(tag, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    idle;
    repeat (3) tick;

    // Reset state, with a live write request that must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_be = 4'hF;
    req_addr = 12'h123; req_wdata = 32'h1234_5678;
    #1;
    check_val("rst_rdy",   32'(req_ready), 32'd0);
    check_val("rst_me",    32'(mem_me),    32'd0);
    check_val("rst_we",    32'(mem_we),    32'd0);
    check_val("rst_adr",   32'(mem_adr),   32'd0);
    check_val("rst_d",     mem_d,          32'd0);
    check_val("rst_vld",   32'(rsp_valid), 32'd0);
    check_val("rst_rdata", rsp_rdata,      32'd0);
    check_val("rst_busy",  32'(busy),      RST_BUSY_EXP);
    tick;
    idle;
    reset = 1'b0;
    #1;
`ifdef SRAM_SP_REQ_CTRL_ZEROIZE_EN
    check_val("zi_rdy",  32'(req_ready), 32'd0);
    check_val("zi_me",   32'(mem_me),    32'd1);
    check_val("zi_we",   32'(mem_we),    32'hF);
    check_val("zi_adr",  32'(mem_adr),   32'd0);
    check_val("zi_busy", 32'(busy),      32'd1);
    wait_ready(5000, "zi_done", n_wait);
    check_val("zi_len", n_wait, 32'd4096);
`else
    check_val("post_rst_rdy",  32'(req_ready), 32'd1);
    check_val("post_rst_busy", 32'(busy),      32'd0);
`endif

    // Full write then read back; no write strobe once the request is gone.
    do_write(12'h005, 32'hDEAD_BEEF, 4'hF, "wr1");
    #1;
    check_val("wr1_after_we", 32'(mem_we), 32'd0);
    read_expect(12'h005, 32'hDEAD_BEEF, "rd1");

    // Partial write merges lanes 0 and 2.
    do_write(12'h010, 32'h1122_3344, 4'hF, "wr2a");
    do_write(12'h010, 32'hAABB_CCDD, 4'b0101, "wr2b");
    read_expect(12'h010, 32'h11BB_33DD, "rd2");

    // be=0 write: accepted, no SRAM access, no response.
    do_write(12'h020, 32'hCAFE_F00D, 4'hF, "wr3");
    do_write(12'h020, 32'h1234_5678, 4'h0, "wr_nop");
    check_val("nop_vld_a", 32'(rsp_valid), 32'd0);
    tick;
    check_val("nop_vld_b", 32'(rsp_valid), 32'd0);
    check_val("nop_busy",  32'(busy),      32'd0);
    read_expect(12'h020, 32'hCAFE_F00D, "rd3");

    // Back-to-back reads against a stalled consumer.
    do_write(12'h030, 32'h1111_0030, 4'hF, "wr4a");
    do_write(12'h031, 32'h2222_0031, 4'hF, "wr4b");
    do_write(12'h032, 32'h3333_0032, 4'hF, "wr4c");
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h030;
    #1;
    check_val("bb_rdy0", 32'(req_ready), 32'd1);
    tick;
    req_addr = 12'h031;
    #1;
    check_val("bb_rdy1", 32'(req_ready), 32'd1);
    tick;
    req_addr = 12'h032;
    #1;
    check_val("bb_rdy_full", 32'(req_ready), 32'd0);
    check_val("bb_vld",      32'(rsp_valid), 32'd1);
    check_val("bb_w1",       rsp_rdata,      32'h1111_0030);
    tick;
    check_val("bb_rdy_full2", 32'(req_ready), 32'd0);
    check_val("bb_hold1",     rsp_rdata,      32'h1111_0030);
    tick;
    check_val("bb_hold2", rsp_rdata, 32'h1111_0030);
    rsp_ready = 1'b1;
    tick;
    check_val("bb_w2",       rsp_rdata,      32'h2222_0031);
    check_val("bb_rdy_back", 32'(req_ready), 32'd1);
    tick;
    idle;
    check_val("bb_gap_vld", 32'(rsp_valid), 32'd0);
    tick;
    check_val("bb_w3_vld", 32'(rsp_valid), 32'd1);
    check_val("bb_w3",     rsp_rdata,      32'h3333_0032);
    tick;
    check_val("bb_empty", 32'(rsp_valid), 32'd0);

    // Reset the cycle after a read accept: the read is dropped.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h005;
    tick;
    idle;
    reset = 1'b1;
    #1;
    check_val("mid_rst_vld",   32'(rsp_valid), 32'd0);
    check_val("mid_rst_rdata", rsp_rdata,      32'd0);
    check_val("mid_rst_rdy",   32'(req_ready), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check_val("mid_rst_no_rsp0", 32'(rsp_valid), 32'd0);
    tick;
    check_val("mid_rst_no_rsp1", 32'(rsp_valid), 32'd0);
    check_val("mid_rst_busy",    32'(busy),      RST_BUSY_EXP);
    tick;
    check_val("mid_rst_no_rsp2", 32'(rsp_valid), 32'd0);
    wait_ready(5000, "mid_rst_ready", n_wait);
    read_expect(12'h005, RD5_AFTER_RST, "rd_after_rst");

`ifdef SRAM_SP_REQ_CTRL_ZEROIZE_EN
    // Pre-fill the top word, reset, and expect the walk to clear it.
    do_write(12'hFFF, 32'h5A5A_5A5A, 4'hF, "zfill");
    read_expect(12'hFFF, 32'h5A5A_5A5A, "zfill_rd");
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    wait_ready(5000, "z2_done", n_wait);
    check_val("z2_len", n_wait, 32'd4096);
    read_expect(12'hFFF, 32'h0000_0000, "z2_rd");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_sp_req_ctrl.md
Name: sram_sp_req_ctrl

Overview:
- Request/response front end that sits directly upstream of the 4k x 32 single-port SRAM wrapper.
- Converts a valid/ready request stream (read, or byte-masked write) into the SRAM strobes ME, WE, ADR and D.
- Captures read data Q into a small response FIFO so the consumer can apply backpressure.
- Optional post-reset zeroize sequencer clears the whole array.

Parameters:
- ADDR_W, 12, SRAM word-address width (4096 words).
- DATA_W, 32, data width; fixed to 4 byte lanes.
- RSP_DEPTH, 2, response FIFO entries (2..8).

Ports:
- CLK  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables for writes; ignored for reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data, in request order.
- busy  out  1  zeroize active, or read in flight, or FIFO not empty.
- mem_me  out  1  to SRAM ME.
- mem_we  out  4  to SRAM WE.
- mem_adr  out  ADDR_W  to SRAM ADR.
- mem_d  out  DATA_W  to SRAM D.
- mem_q  in  DATA_W  from SRAM Q; valid the cycle after a read access.

Behaviour:
- Accept rule: a request is accepted when req_valid & req_ready.
- req_ready independence: req_ready never depends on req_valid, req_write or req_be.
  - req_ready = !zeroize_active & (fifo_count + rd_inflight < RSP_DEPTH).
  - Writes are also stalled when credits are exhausted (simple, order-preserving).
- SRAM drive (combinational from the request):
  - mem_adr = req_addr; mem_d = req_wdata.
  - mem_me = accept & !(req_write & req_be==0).
  - mem_we = accept & req_write ? req_be : 0.
- Write with req_be==4'h0: accepted as a no-op. mem_me=0, no SRAM access, no response.
- Read:
  - rd_inflight is set in the accept cycle.
  - Next cycle mem_q is pushed into the FIFO and rd_inflight clears.
  - Back-to-back reads give one read per cycle while credits allow.
- Read latency: accept at cycle N -> rsp_valid earliest at N+2. The FIFO output is registered; first-word fall-through is not used.
- Writes produce no response. A read following a write to the same address returns the new data; the SRAM array order guarantees this.
- FIFO:
  - Push and pop in the same cycle keep count unchanged.
  - Credit accounting counts the in-flight read, so the FIFO never overflows.
  - Pop when empty is impossible, since rsp_valid = count != 0.
- rsp_rdata holds stable while rsp_valid & !rsp_ready.
- Reset (synchronous, any time, including mid-read):
  - FIFO count = 0, rd_inflight = 0, any in-flight read is discarded.
  - Outputs in the reset cycle and after: rsp_valid=0, rsp_rdata=0, mem_me=0, mem_we=0, mem_adr=0, mem_d=0.
  - req_ready=0 while reset is high.
  - busy=0 when the feature is off; busy=1 when the feature is on.
- Pointer wrap: FIFO pointers wrap modulo RSP_DEPTH. Addresses do not wrap; each request is a single word.

Optional Feature:
- Macro: SRAM_SP_REQ_CTRL_ZEROIZE_EN.
- Defined:
  - After reset deasserts, zeroize_active=1 and a counter walks addresses 0..2^ADDR_W-1.
  - One write per cycle: mem_me=1, mem_we=4'hF, mem_d=0.
  - Takes 4096 cycles. req_ready=0 and busy=1 throughout.
  - req_ready rises in the cycle after address 4095 is written.
  - Reset during zeroize restarts the walk at address 0.
- Not defined: no counter logic. req_ready is governed by credits only, starting the first cycle after reset.

Test Plan:
- Write 0xDEADBEEF to addr 0x005 with be=4'hF, then read 0x005 -> rsp_rdata=0xDEADBEEF at accept+2; mem_we=4'hF only in the write cycle.
- Write 0x11223344 to 0x010; write 0xAABBCCDD to 0x010 with be=4'b0101; read 0x010 -> 0x11BB33DD.
- Write with be=4'h0 to 0x020 -> mem_me=0 that cycle; a later read of 0x020 returns the prior value; no response for the write.
- Three back-to-back reads with rsp_ready=0 (RSP_DEPTH=2):
  - req_ready=0 after the second accept; rsp_rdata holds the first word.
  - Raise rsp_ready -> three responses in order, req_ready returns.
- Assert reset in the cycle after a read accept -> no response ever appears; rsp_valid=0; FIFO empty.
- With ZEROIZE_EN defined: pre-fill 0xFFF with 0x5A5A5A5A, then reset.
  - req_ready=0 for 4096 cycles.
  - Then a read of 0xFFF returns 0x00000000.
